// File: rtl/nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : nibble_serial_adder_ctrl
// Purpose  : Adds two WIDTH-bit operands by time-sharing a single 4-bit
//            adder slice, one nibble per clock, least-significant first.
//            The inter-nibble carry lives in a register and the result is
//            assembled in a shift register.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            in_valid/in_ready, A, B, Cin    - operand handshake
//            out_valid/out_ready, Sum, Cout  - result handshake
//            busy            - high while nibbles are being processed
//            op_sub          - (optional) subtract A - B - Cin
// Options  : define NIBBLE_SERIAL_ADDER_SUB_EN to add the op_sub port.
// Revision : 1.0 - initial release
// ============================================================================
module nibble_serial_adder_ctrl #(
  parameter  int NIBBLES = 4,
  localparam int WIDTH   = 4 * NIBBLES,
  localparam int CNT_W   = $clog2(NIBBLES) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  input  logic             op_sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NIBBLES - 1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               out_valid_q, out_valid_d;

  logic [3:0]         w_b_nib;
  logic [4:0]         w_slice;
  logic [WIDTH-1:0]   w_sum_shift;
  logic               w_init_carry;

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  logic               op_sub_q, op_sub_d;

  // Subtraction is A + ~B + ~Cin: inverting B and the incoming carry turns
  // the adder into A - B - Cin, with Cout=1 meaning no borrow.
  assign w_b_nib      = op_sub_q ? ~b_q[3:0] : b_q[3:0];
  assign w_init_carry = op_sub ? ~Cin : Cin;
`else
  assign w_b_nib      = b_q[3:0];
  assign w_init_carry = Cin;
`endif

  // The shared 4-bit slice always works on the low nibble of the operand
  // registers; the operands shift right by one nibble every RUN cycle.
  assign w_slice = {1'b0, a_q[3:0]} + {1'b0, w_b_nib} + {4'b0000, carry_q};

  // Result nibbles enter at the top and migrate down, so after NIBBLES
  // shifts nibble 0 sits in the least-significant position.
  generate
    if (NIBBLES == 1) begin : g_single
      assign w_sum_shift = w_slice[3:0];
    end else begin : g_multi
      assign w_sum_shift = {w_slice[3:0], sum_q[WIDTH-1:4]};
    end
  endgenerate

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    idx_d       = idx_q;
    carry_d     = carry_q;
    cout_d      = cout_q;
    out_valid_d = out_valid_q;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    op_sub_d    = op_sub_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = A;
          b_d     = B;
          carry_d = w_init_carry;
          idx_d   = '0;
          sum_d   = '0;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
          op_sub_d = op_sub;
`endif
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        a_d     = a_q >> 4;
        b_d     = b_q >> 4;
        sum_d   = w_sum_shift;
        carry_d = w_slice[4];
        idx_d   = idx_q + CNT_W'(1);
        if (idx_q == LAST_IDX) begin
          cout_d      = w_slice[4];
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
      op_sub_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      idx_q       <= idx_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
      op_sub_q    <= op_sub_d;
`endif
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign busy      = (state_q == S_RUN);
  assign out_valid = out_valid_q;
  assign Sum       = sum_q;
  assign Cout      = cout_q;

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_adder_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_serial_adder_ctrl
// Purpose  : Self-checking bench for nibble_serial_adder_ctrl (NIBBLES=4 and
//            NIBBLES=1 instances) using a result scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_adder_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // NIBBLES=4 instance
  logic        rst, in_valid, Cin, out_ready;
  logic [15:0] A, B;
  logic        in_ready, out_valid, Cout, busy;
  logic [15:0] Sum;
  logic        op_sub;

  // NIBBLES=1 instance
  logic        in_valid1, cin1, out_ready1;
  logic [3:0]  a1, b1;
  logic        in_ready1, out_valid1, cout1, busy1;
  logic [3:0]  sum1;

  nibble_serial_adder_ctrl #(.NIBBLES(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cin(Cin),
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    .op_sub(op_sub),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .Sum(Sum), .Cout(Cout),
    .busy(busy)
  );

  nibble_serial_adder_ctrl #(.NIBBLES(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid1), .in_ready(in_ready1),
    .A(a1), .B(b1), .Cin(cin1),
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    .op_sub(1'b0),
`endif
    .out_valid(out_valid1), .out_ready(out_ready1), .Sum(sum1), .Cout(cout1),
    .busy(busy1)
  );

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  logic [16:0] sb[$];
  logic [4:0]  sb1[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_check(input string tag, output logic [16:0] e);
    e = '0;
    check({tag, " sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, " Sum"},  32'(Sum),  32'(e[15:0]));
      check({tag, " Cout"}, 32'(Cout), 32'(e[16]));
    end
  endtask

  // Offer one operand set to dut4 with out_ready=1 and check the full
  // transaction: latency, busy length, result and return to IDLE.
  task automatic run_add(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic cin, input logic sub);
    int          lat, busy_cnt, guard;
    logic [16:0] exp;
    guard = 0;
    while (!in_ready && guard < 50) begin tick(); guard++; end
    A = a; B = b; Cin = cin; op_sub = sub;
    in_valid = 1'b1; out_ready = 1'b1;
    if (sub) exp = {1'b0, a} + {1'b0, ~b} + 17'(!cin);
    else     exp = {1'b0, a} + {1'b0, b} + 17'(cin);
    sb.push_back(exp);
    tick();                         // accept edge
    in_valid = 1'b0;
    A = 16'($urandom); B = 16'($urandom); Cin = 1'($urandom);
    lat = 0; busy_cnt = 0;
    while (!out_valid && lat < 20) begin
      if (busy) busy_cnt++;
      tick();
      lat++;
    end
    check({tag, " latency"}, 32'(lat), 32'd4);
    check({tag, " busy_cycles"}, 32'(busy_cnt), 32'd4);
    pop_check(tag, exp);
    tick();
    check({tag, " back_to_idle"}, {30'd0, out_valid, in_ready}, 32'b01);
  endtask

  initial begin
    logic [16:0] e;
    logic [4:0]  e1;
    int          lat;
    rst = 1'b1; in_valid = 1'b0; A = '0; B = '0; Cin = 1'b0; out_ready = 1'b0;
    op_sub = 1'b0;
    in_valid1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0; out_ready1 = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    check("reset in_ready",  32'(in_ready),  32'd1);
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset Sum",       32'(Sum),       32'd0);
    check("reset Cout",      32'(Cout),      32'd0);
    check("reset busy",      32'(busy),      32'd0);
    check("reset1 out_valid", 32'(out_valid1), 32'd0);
    check("reset1 Sum",      32'(sum1),      32'd0);

    // Basic add and full carry ripple
    run_add("basic",  16'h1234, 16'h1111, 1'b0, 1'b0);
    run_add("ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
    run_add("allones", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);

    // Backpressure and input blocking: in_valid stays high throughout
    out_ready = 1'b0;
    A = 16'hABCD; B = 16'h1234; Cin = 1'b0; in_valid = 1'b1;
    sb.push_back(17'h0BE01);
    tick();
    check("bp run in_ready", 32'(in_ready), 32'd0);
    check("bp run busy",     32'(busy),     32'd1);
    A = 16'h0101; B = 16'h0202; Cin = 1'b0;
    lat = 0;
    while (!out_valid && lat < 20) begin tick(); lat++; end
    check("bp latency", 32'(lat), 32'd4);
    pop_check("bp", e);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp hold", {13'd0, out_valid, in_ready, Cout, Sum}, {13'd0, 1'b1, 1'b0, e[16], e[15:0]});
    end
    out_ready = 1'b1;
    tick();
    check("bp release", {30'd0, out_valid, in_ready}, 32'b01);
    sb.push_back(17'h00303);
    tick();
    in_valid = 1'b0;
    check("bp second busy", 32'(busy), 32'd1);
    lat = 0;
    while (!out_valid && lat < 20) begin tick(); lat++; end
    check("bp second latency", 32'(lat), 32'd4);
    pop_check("bp second", e);
    tick();

    // Reset in the middle of RUN (index 2)
    A = 16'h1111; B = 16'h2222; Cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    check("midrst busy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst in_ready",  32'(in_ready),  32'd1);
    check("midrst out_valid", 32'(out_valid), 32'd0);
    check("midrst Sum",       32'(Sum),       32'd0);
    check("midrst Cout",      32'(Cout),      32'd0);
    check("midrst busy0",     32'(busy),      32'd0);
    run_add("after_rst", 16'h0F0F, 16'h00F1, 1'b0, 1'b0);

    // Single-nibble instance
    a1 = 4'h9; b1 = 4'h8; cin1 = 1'b1; in_valid1 = 1'b1; out_ready1 = 1'b1;
    sb1.push_back(5'({1'b0, a1} + {1'b0, b1} + 5'(cin1)));
    tick();
    in_valid1 = 1'b0;
    lat = 0;
    while (!out_valid1 && lat < 20) begin tick(); lat++; end
    check("n1 latency", 32'(lat), 32'd1);
    check("n1 sb_nonempty", 32'(sb1.size() != 0), 32'd1);
    if (sb1.size() != 0) begin
      e1 = sb1.pop_front();
      check("n1 Sum",  32'(sum1),  32'(e1[3:0]));
      check("n1 Cout", 32'(cout1), 32'(e1[4]));
    end
    tick();
    check("n1 back_to_idle", {30'd0, out_valid1, in_ready1}, 32'b01);

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    run_add("sub_borrow",   16'h0005, 16'h0007, 1'b0, 1'b1);
    run_add("sub_noborrow", 16'h0007, 16'h0005, 1'b0, 1'b1);
`endif

    check("sb drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
- Sequencer that adds two WIDTH-bit operands by time-sharing one 4-bit ripple full-adder slice, one nibble per clock, least-significant nibble first.
- Holds the carry between nibbles in a register and assembles the result in a shift register.
- Valid/ready handshake on input and output.
- Sits between the operand source and the consumer wherever area matters more than latency.

Parameters:
- NIBBLES, 4, operand width in nibbles (≥1); WIDTH = 4*NIBBLES.
- CNT_W, $clog2(NIBBLES)+1, nibble index counter width (derived, not overridden).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operand set offered.
- in_ready  output  1  block can accept operands (high only in IDLE).
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- Cin  input  1  carry-in into nibble 0.
- out_valid  output  1  result available; held until taken.
- out_ready  input  1  consumer takes result.
- Sum  output  WIDTH  result; stable while out_valid=1.
- Cout  output  1  carry out of nibble NIBBLES-1.
- busy  output  1  high in RUN.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE, out_valid=0, Sum=0, Cout=0, busy=0, carry reg=0, index=0. Applies from any state; an in-flight addition is aborted and its result discarded.
- States:
  - IDLE: in_ready=1. If in_valid=1 at edge k (accept), latch A, B, and Cin into the carry reg; set index=0; go to RUN.
  - RUN: busy=1, in_ready=0. Each edge feeds A[4i+3:4i], B[4i+3:4i], and the carry reg into the 4-bit slice. Slice sum is written into Sum nibble i; slice carry-out goes into the carry reg; index increments. At the edge with i=NIBBLES-1: Cout=slice carry-out, out_valid=1, go to DONE.
  - DONE: out_valid=1, Sum and Cout held. On an edge with out_ready=1: out_valid=0, go to IDLE.
- Latency: accept at edge k → out_valid high after edge k+NIBBLES. Minimum issue interval NIBBLES+2 cycles (no back-to-back overlap).
- in_valid is ignored outside IDLE; operands are not queued. The source must hold operands until in_ready&in_valid.
- Inputs A/B/Cin changing during RUN have no effect (latched copies are used).
- out_ready while out_valid=0: ignored.
- Sum nibbles not yet computed in RUN are don't-care to the consumer. They are cleared to 0 at accept.
- Arithmetic: {Cout,Sum} = A + B + Cin, modulo 2^(WIDTH+1). No saturation.
- NIBBLES=1: accept → RUN one cycle → DONE.

Optional Feature:
- Macro: NIBBLE_SERIAL_ADDER_SUB_EN.
- Defined: extra input port op_sub (1 bit), latched at accept. When op_sub=1, each B nibble is inverted before the slice and the initial carry = ~Cin, giving Sum = A - B - Cin. Cout=1 means no borrow.
- Not defined: port absent; add only, as above.

Test Plan:
- Basic add: NIBBLES=4, A=0x1234, B=0x1111, Cin=0, out_ready=1 → out_valid after edge k+4, Sum=0x2345, Cout=0, busy high for exactly 4 cycles.
- Full carry ripple: A=0xFFFF, B=0x0001, Cin=0 → Sum=0x0000, Cout=1. A=0xFFFF, B=0xFFFF, Cin=1 → Sum=0xFFFF, Cout=1.
- Output backpressure and input blocking:
  - out_ready=0 for 10 cycles after out_valid: Sum/Cout/out_valid stable, in_ready=0.
  - A second in_valid during RUN/DONE is not accepted.
  - Raising out_ready → IDLE next edge; then the second operand set is accepted.
- Reset mid-operation: assert rst at RUN index 2 → next cycle IDLE, out_valid=0, Sum=0, Cout=0. A new add of 0x0F0F+0x00F1 then completes correctly with Sum=0x1000, Cout=0.
- NIBBLES=1 instance: A=0x9, B=0x8, Cin=1 → Sum=0x2, Cout=1; out_valid after edge k+1.
- With NIBBLE_SERIAL_ADDER_SUB_EN: op_sub=1, A=0x0005, B=0x0007, Cin=0 → Sum=0xFFFE, Cout=0. Then A=0x0007, B=0x0005 → Sum=0x0002, Cout=1.
